regfile_write_arbiter: RTL and testbench

Write-side controller for the decode-stage register file. It merges two writeback sources onto the register file's single write port (address, enable, data): the in-order pipeline writeback, and a long-latency unit (load/divide) that returns results through a valid/ready handshake into a small FIFO. It also keeps a per-register pending scoreboard so decode can stall on source registers whose long-latency result has not yet been written.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/wb_fifo.sv | 68 ++++++
 rtl/regfile_write_arbiter.sv | 89 ++++++++
 tb/tb_regfile_write_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and the buffered writeback entry type for the register file write side.
package regfile_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDRESS_WIDTH = 5;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding long-latency writeback results until a pipeline-idle cycle.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t push_data,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     mem_d [DEPTH];
    logic          do_push, do_pop;

    // A full FIFO refuses a push even while popping; no pop-through path.
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline writeback and buffered long-latency results onto the single register
// file write port, and tracks registers whose long-latency result is still outstanding.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we,
    input  logic [ADDRESS_WIDTH-1:0] pipe_rd,
    input  logic [DATA_WIDTH-1:0]    pipe_wd,
    input  logic                     issue_valid,
    input  logic [ADDRESS_WIDTH-1:0] issue_rd,
    input  logic                     ll_valid,
    input  logic [ADDRESS_WIDTH-1:0] ll_rd,
    input  logic [DATA_WIDTH-1:0]    ll_wd,
    output logic                     ll_ready,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    output logic                     stall,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] A3,
    output logic [DATA_WIDTH-1:0]    WD3
);

    localparam int NREGS = 2**ADDRESS_WIDTH;

    logic            pipe_active;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    wb_entry_t       fifo_head, ll_entry;
    logic [NREGS-1:0] pending_q, pending_d;

    // A pipeline write to x0 is treated as idle so the FIFO may drain.
    assign pipe_active = pipe_we && (pipe_rd != '0);
    assign ll_ready    = !rst && !fifo_full;
    assign fifo_push   = ll_valid && ll_ready && (ll_rd != '0);
    assign fifo_pop    = !rst && !pipe_active && !fifo_empty;
    assign ll_entry    = {ll_rd, ll_wd};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (ll_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_comb begin
        WE3 = 1'b0;
        A3  = '0;
        WD3 = '0;
        if (pipe_active && !rst) begin
            WE3 = 1'b1;
            A3  = pipe_rd;
            WD3 = pipe_wd;
        end else if (fifo_pop) begin
            WE3 = 1'b1;
            A3  = fifo_head.rd;
            WD3 = fifo_head.wd;
        end
    end

    // Clear is applied before set so a same-register issue in the popping cycle wins.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop) begin
            pending_d[fifo_head.rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign stall = !rst && (pending_q[rs1] || pending_q[rs2]);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-sequence bench with a behavioural queue model of buffered results and pending bits.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        ll_valid;
    logic [4:0]  ll_rd;
    logic [31:0] ll_wd;
    logic        ll_ready;
    logic [4:0]  rs1, rs2;
    logic        stall;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;

    int          total = 0;
    int          bad   = 0;
    logic [36:0] exp_q [$];
    logic [31:0] model_pending = '0;

    regfile_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_wd     (pipe_wd),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .ll_valid    (ll_valid),
        .ll_rd       (ll_rd),
        .ll_wd       (ll_wd),
        .ll_ready    (ll_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .stall       (stall),
        .WE3         (WE3),
        .A3          (A3),
        .WD3         (WD3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic pwe, input logic [4:0] prd, input logic [31:0] pwd,
                                  input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                                  input logic iv, input logic [4:0] ird);
        pipe_we     = pwe;
        pipe_rd     = prd;
        pipe_wd     = pwd;
        ll_valid    = lv;
        ll_rd       = lrd;
        ll_wd       = lwd;
        issue_valid = iv;
        issue_rd    = ird;
    endtask

    task automatic apply_idle();
        apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Checks the current cycle against the model, then advances the model across the edge.
    task automatic check_output();
        logic        pipe_act, drain, accept;
        logic [36:0] head;
        @(negedge clk);
        pipe_act = pipe_we && (pipe_rd != 5'd0);
        drain    = !rst && !pipe_act && (exp_q.size() > 0);
        head     = (exp_q.size() > 0) ? exp_q[0] : 37'd0;
        if (rst) begin
            chk("we3_in_reset", 64'(WE3), 64'd0);
            chk("ll_ready_in_reset", 64'(ll_ready), 64'd0);
            chk("stall_in_reset", 64'(stall), 64'd0);
        end else begin
            chk("ll_ready", 64'(ll_ready), 64'(exp_q.size() < DEPTH));
            chk("stall", 64'(stall), 64'(model_pending[rs1] | model_pending[rs2]));
            if (pipe_act) begin
                chk("we3_pipe", 64'(WE3), 64'd1);
                chk("a3_pipe", 64'(A3), 64'(pipe_rd));
                chk("wd3_pipe", 64'(WD3), 64'(pipe_wd));
            end else if (drain) begin
                chk("we3_fifo", 64'(WE3), 64'd1);
                chk("a3_fifo", 64'(A3), 64'(head[36:32]));
                chk("wd3_fifo", 64'(WD3), 64'(head[31:0]));
            end else begin
                chk("we3_idle", 64'(WE3), 64'd0);
                chk("a3_idle", 64'(A3), 64'd0);
                chk("wd3_idle", 64'(WD3), 64'd0);
            end
        end
        accept = !rst && ll_valid && (exp_q.size() < DEPTH) && (ll_rd != 5'd0);
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            model_pending = '0;
        end else begin
            if (drain) begin
                model_pending[head[36:32]] = 1'b0;
                void'(exp_q.pop_front());
            end
            if (issue_valid && (issue_rd != 5'd0)) model_pending[issue_rd] = 1'b1;
            if (accept) exp_q.push_back({ll_rd, ll_wd});
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rs1 = 5'd0;
        rs2 = 5'd0;
        apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h5555, 1'b0, 5'd0);
        check_output();
        check_output();
        rst = 1'b0;
        apply_idle();
        check_output();

        // Pipeline priority over a buffered result
        apply_stimulus(1'b1, 5'd1, 32'h1111, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
        check_output();
        apply_stimulus(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_output();
        apply_idle();
        check_output();

        // x0 pipeline write lets the FIFO drain; ll result to x0 is dropped
        apply_stimulus(1'b1, 5'd2, 32'h2222, 1'b1, 5'd3, 32'hAA, 1'b0, 5'd0);
        check_output();
        apply_stimulus(1'b1, 5'd0, 32'hBEEF, 1'b1, 5'd0, 32'h77, 1'b0, 5'd0);
        check_output();
        apply_idle();
        check_output();

        // Fill under constant pipeline traffic, then observe backpressure release
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 5'd1, 32'(i), 1'b1, 5'(10 + i), 32'hF000 + 32'(i), 1'b0, 5'd0);
            check_output();
        end
        apply_idle();
        check_output();
        apply_stimulus(1'b1, 5'd1, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_output();
        repeat (4) begin
            apply_idle();
            check_output();
        end

        // Wrap-around with mixed pipeline load
        for (int i = 0; i < 20; i++) begin
            apply_stimulus((i % 3) != 0, 5'd1, 32'(i), 1'b1, 5'((i % 30) + 1),
                           32'hC0DE_0000 + 32'(i), 1'b0, 5'd0);
            check_output();
        end
        repeat (6) begin
            apply_idle();
            check_output();
        end

        // Scoreboard set and clear on register 9
        rs1 = 5'd9;
        rs2 = 5'd0;
        apply_stimulus(1'b1, 5'd1, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        check_output();
        apply_stimulus(1'b1, 5'd1, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
        check_output();
        apply_idle();
        check_output();
        apply_idle();
        check_output();

        // Same-cycle issue and pop of register 9 keeps it pending
        apply_stimulus(1'b1, 5'd1, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        check_output();
        apply_stimulus(1'b1, 5'd1, 32'd0, 1'b1, 5'd9, 32'h9A, 1'b0, 5'd0);
        check_output();
        apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        check_output();
        apply_idle();
        check_output();
        apply_stimulus(1'b1, 5'd1, 32'd0, 1'b1, 5'd9, 32'h9B, 1'b0, 5'd0);
        check_output();
        apply_idle();
        check_output();
        apply_idle();
        check_output();

        // Mid-operation reset discards buffered entries and pending bits
        rs1 = 5'd4;
        rs2 = 5'd6;
        apply_stimulus(1'b1, 5'd1, 32'd0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4);
        check_output();
        apply_stimulus(1'b1, 5'd1, 32'd0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd6);
        check_output();
        apply_stimulus(1'b1, 5'd1, 32'd0, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0);
        check_output();
        rst = 1'b1;
        apply_idle();
        check_output();
        rst = 1'b0;
        repeat (3) begin
            apply_idle();
            check_output();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
